// File: rtl/snn_image_loader.sv
// ---------------------------------------------------------------------------
// snn_image_loader
//
// Receive-side front end of the SNN top level. Bytes arriving from uart_rx
// are unpacked LSB-first into the 1-bit-wide input RAM (8*NUM_BYTES bits).
// Once a full image is stored, start is pulsed to the core. The classified
// digit reported by the core is latched onto led and returned as one byte
// through uart_tx.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rx_rdy, rx_data      byte strobe and data from uart_rx
//   ram_we/addr/wdata    input RAM bit write port
//   start                one-cycle pulse: image loaded
//   done, digit          one-cycle result strobe and digit from the core
//   tx_start, tx_data    byte request to uart_tx
//   tx_rdy               uart_tx idle
//   led                  last classified digit, zero-extended
//   busy                 high whenever the loader is not waiting for a byte
//   overrun              sticky flag: a received byte was dropped
//
// Build option: define SNN_LOADER_TIMEOUT_EN to add an inter-byte timeout
// that discards a partially received image after TIMEOUT_CYCLES idle cycles.
// ---------------------------------------------------------------------------
module snn_image_loader #(
    parameter int NUM_BYTES      = 98,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    output logic              start,
    input  logic              done,
    input  logic [3:0]        digit,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_rdy,
    output logic [7:0]        led,
    output logic              busy,
    output logic              overrun
);

    localparam int BC_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(NUM_BYTES - 1);
    localparam logic [BC_W-1:0]   BC_ONE   = BC_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_LOAD, S_WRITE, S_START, S_WAIT_CORE, S_SEND
    } state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        byte_reg_q, byte_reg_d;
    logic [7:0]        hold_reg_q, hold_reg_d;
    logic              hold_vld_q, hold_vld_d;
    logic              overrun_q, overrun_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wdata_q, ram_wdata_d;
    logic              start_q, start_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        led_q, led_d;
    logic              busy_q, busy_d;

    // A buffered byte always has priority over a fresh one so order is kept.
    logic       accept;
    logic [7:0] in_byte;
    assign accept  = hold_vld_q || rx_rdy;
    assign in_byte = hold_vld_q ? hold_reg_q : rx_data;

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_LOAD;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:      if (accept) state_d = S_WRITE;
            S_WRITE:     if (bit_cnt_q == 3'd7)
                             state_d = (byte_cnt_q == BC_LAST) ? S_START : S_LOAD;
            S_START:     state_d = S_WAIT_CORE;
            S_WAIT_CORE: if (done) state_d = S_SEND;
            S_SEND:      if (tx_rdy) state_d = S_LOAD;
            default:     state_d = S_LOAD;
        endcase
    end

    // Output / datapath logic. The RAM port is registered, so the bit shown
    // on it during a cycle is the one selected on the previous edge; bit_cnt
    // tracks the bit currently presented.
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        byte_reg_d  = byte_reg_q;
        hold_reg_d  = hold_reg_q;
        hold_vld_d  = hold_vld_q;
        overrun_d   = overrun_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        start_d     = 1'b0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        led_d       = led_q;
`ifdef SNN_LOADER_TIMEOUT_EN
        to_cnt_d    = '0;
`endif
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    byte_reg_d  = in_byte;
                    bit_cnt_d   = 3'd0;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = ADDR_W'({byte_cnt_q, 3'b000});
                    ram_wdata_d = in_byte[0];
                    // Taking the buffered byte while a new one arrives: the
                    // new byte refills the buffer, nothing is lost.
                    if (hold_vld_q) begin
                        if (rx_rdy) hold_reg_d = rx_data;
                        else        hold_vld_d = 1'b0;
                    end
                end
`ifdef SNN_LOADER_TIMEOUT_EN
                // Idle mid-image for too long: resync to byte 0.
                if (!accept && byte_cnt_q != '0) begin
                    if (to_cnt_q == TO_LAST) begin
                        byte_cnt_d = '0;
                        hold_vld_d = 1'b0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_ONE;
                    end
                end
`endif
            end
            S_WRITE: begin
                if (rx_rdy) begin
                    if (hold_vld_q) overrun_d = 1'b1;
                    else begin
                        hold_reg_d = rx_data;
                        hold_vld_d = 1'b1;
                    end
                end
                if (bit_cnt_q != 3'd7) begin
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = ram_addr_q + ADDR_ONE;
                    ram_wdata_d = byte_reg_q[bit_cnt_d];
                end else if (byte_cnt_q == BC_LAST) begin
                    byte_cnt_d = '0;
                    start_d    = 1'b1;
                end else begin
                    byte_cnt_d = byte_cnt_q + BC_ONE;
                end
            end
            S_START: begin
                if (rx_rdy) overrun_d = 1'b1;
            end
            S_WAIT_CORE: begin
                if (rx_rdy) overrun_d = 1'b1;
                if (done) begin
                    led_d     = {4'h0, digit};
                    tx_data_d = {4'h0, digit};
                end
            end
            S_SEND: begin
                if (rx_rdy) overrun_d = 1'b1;
                if (tx_rdy) tx_start_d = 1'b1;
            end
            default: ;
        endcase
        busy_d = (state_d != S_LOAD);
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q  <= '0;
            bit_cnt_q   <= 3'd0;
            hold_vld_q  <= 1'b0;
            overrun_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 1'b0;
            start_q     <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            led_q       <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_vld_q  <= hold_vld_d;
            overrun_q   <= overrun_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            start_q     <= start_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SNN_LOADER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`endif

    // Byte data registers; only meaningful when qualified by control state.
    always_ff @(posedge clk) begin
        byte_reg_q <= byte_reg_d;
        hold_reg_q <= hold_reg_d;
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign start     = start_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign led       = led_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_snn_image_loader.sv
// ---------------------------------------------------------------------------
// tb_snn_image_loader
//
// Directed sequence with randomized byte contents and spacing. The bench
// keeps a list of bytes it expects to be stored and rebuilds the expected
// RAM image from it (bit j of stored byte i lives at address 8*i+j).
// Build with SNN_LOADER_TIMEOUT_EN to add the timeout scenario.
// ---------------------------------------------------------------------------
module tb_snn_image_loader;

    localparam int NB    = 98;
    localparam int NBITS = 8 * NB;
    localparam int TB_TO = 300;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic       ram_wdata;
    logic       start;
    logic       done;
    logic [3:0] digit;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_rdy;
    logic [7:0] led;
    logic       busy;
    logic       overrun;

    snn_image_loader #(
        .NUM_BYTES(NB), .ADDR_W(10), .TIMEOUT_CYCLES(TB_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .start(start), .done(done), .digit(digit),
        .tx_start(tx_start), .tx_data(tx_data), .tx_rdy(tx_rdy),
        .led(led), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitors: RAM model, start counter and uart_rx model.
    logic       act_mem     [0:1023];
    int         wr_cyc      [0:1023];
    logic [9:0] wr_addr_log [0:16383];
    logic [7:0] rxb         [0:63];
    int wr_cnt = 0, start_cnt = 0, start_cyc = 0;
    int tx_cnt = 0, tx_cyc = 0, tx_viol = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) begin
                act_mem[ram_addr]   <= ram_wdata;
                wr_cyc[ram_addr]    <= cyc;
                wr_addr_log[wr_cnt] <= ram_addr;
                wr_cnt              <= wr_cnt + 1;
            end
            if (start) begin
                start_cnt <= start_cnt + 1;
                start_cyc <= cyc;
            end
            if (tx_start) begin
                rxb[tx_cnt[5:0]] <= tx_data;
                tx_cnt           <= tx_cnt + 1;
                tx_cyc           <= cyc;
                if (!tx_rdy) tx_viol <= tx_viol + 1;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stimulus lists: bytes to pulse, period to next pulse, bytes expected stored.
    logic [7:0] tx_b[$];
    int         tx_p[$];
    logic [7:0] exp_b[$];
    int pulse0  = 0;
    int wr_base = 0;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add(input logic [7:0] b, input int per, input bit kept);
        tx_b.push_back(b);
        tx_p.push_back(per);
        if (kept) exp_b.push_back(b);
    endtask

    // A short period (< 9) parks the byte in the skid buffer; the following
    // gap is made long enough for both bytes to drain.
    task automatic build_random(input int n, input bit fixed, input logic [7:0] fb);
        bit prev_short;
        int p;
        prev_short = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1)                 p = 20;
            else if (prev_short)            p = $urandom_range(24, 18);
            else if ($urandom_range(4, 0) == 0) p = $urandom_range(8, 1);
            else                            p = $urandom_range(14, 9);
            prev_short = (p < 9);
            add(fixed ? fb : 8'($urandom), p, 1'b1);
        end
    endtask

    task automatic play();
        for (int i = 0; i < tx_b.size(); i++) begin
            rx_data = tx_b[i];
            rx_rdy  = 1'b1;
            if (i == 0) pulse0 = cyc;
            @(posedge clk);
            #1;
            rx_rdy = 1'b0;
            idle(tx_p[i] - 1);
        end
        tx_b.delete();
        tx_p.delete();
    endtask

    task automatic new_image();
        exp_b.delete();
        wr_base = wr_cnt;
    endtask

    task automatic finish_image(input int exp_starts);
        int n;
        int mism;
        logic [7:0] b;
        n = 0;
        while (start_cnt < exp_starts && n < 2000) begin
            idle(1);
            n++;
        end
        check("start_count", start_cnt, exp_starts);
        check("start_after_last_write", start_cyc, wr_cyc[NBITS-1] + 1);
        check("write_count", wr_cnt - wr_base, NBITS);
        mism = 0;
        for (int a = 0; a < NBITS; a++) begin
            b = exp_b[a / 8];
            if (act_mem[a] !== b[a % 8]) mism++;
        end
        check("image_bits", mism, 0);
        check("busy_wait_core", busy, 1);
    endtask

    task automatic wait_tx(input int n, input logic [7:0] exp);
        int k;
        k = 0;
        while (tx_cnt < n && k < 100) begin
            idle(1);
            k++;
        end
        check("tx_count", tx_cnt, n);
        check("uart_rx_byte", rxb[(n - 1) % 64], exp);
    endtask

    task automatic core_done(input logic [3:0] d, input bit expect_tx);
        int dcyc;
        int n0;
        n0    = tx_cnt;
        digit = d;
        done  = 1'b1;
        dcyc  = cyc;
        @(posedge clk);
        #1;
        done = 1'b0;
        check("led", led, {4'h0, d});
        check("tx_data", tx_data, {4'h0, d});
        if (expect_tx) begin
            wait_tx(n0 + 1, {4'h0, d});
            check("tx_latency", tx_cyc, dcyc + 2);
            check("busy_idle", busy, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int rcyc;
        rst_n   = 1'b0;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        done    = 1'b0;
        digit   = 4'h0;
        tx_rdy  = 1'b1;
        idle(3);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_start", start, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_led", led, 0);
        rst_n = 1'b1;
        idle(2);

        // Image of 0xA5 bytes, then digit 7 returned.
        new_image();
        build_random(NB, 1'b1, 8'hA5);
        play();
        check("byte0_first_write", wr_cyc[0], pulse0 + 1);
        check("byte0_last_write", wr_cyc[7], pulse0 + 8);
        finish_image(1);
        core_done(4'h7, 1'b1);
        idle(30);
        check("single_start", start_cnt, 1);

        // Back-to-back images: digits 0, 2 (uart_tx busy at done) and 9.
        new_image();
        build_random(NB, 1'b0, 8'h00);
        play();
        finish_image(2);
        core_done(4'h0, 1'b1);

        new_image();
        build_random(NB, 1'b0, 8'h00);
        play();
        finish_image(3);
        n0     = tx_cnt;
        tx_rdy = 1'b0;
        core_done(4'h2, 1'b0);
        idle(15);
        check("tx_waits_for_rdy", tx_cnt, n0);
        check("busy_send", busy, 1);
        tx_rdy = 1'b1;
        rcyc   = cyc;
        wait_tx(n0 + 1, 8'h02);
        check("tx_after_rdy", tx_cyc, rcyc + 1);

        new_image();
        build_random(NB, 1'b0, 8'h00);
        play();
        finish_image(4);
        core_done(4'h9, 1'b1);
        check("led_last", led, 8'h09);
        check("no_overrun_b2b", overrun, 0);

        // Skid buffer: buffered byte and new byte coincide in LOAD (no loss),
        // then three bytes on consecutive cycles (third one dropped).
        new_image();
        build_random(5, 1'b0, 8'h00);
        add(8'($urandom), 3, 1'b1);
        add(8'($urandom), 6, 1'b1);
        add(8'($urandom), 20, 1'b1);
        build_random(12, 1'b0, 8'h00);
        play();
        check("no_loss_overrun", overrun, 0);
        add(8'($urandom), 1, 1'b1);
        add(8'($urandom), 1, 1'b1);
        add(8'($urandom), 20, 1'b0);
        play();
        check("overrun_set", overrun, 1);
        build_random(NB - 22, 1'b0, 8'h00);
        play();
        finish_image(5);
        check("overrun_sticky", overrun, 1);
        core_done(4'h3, 1'b1);

        // Reset while byte 40 is being written.
        new_image();
        build_random(39, 1'b0, 8'h00);
        add(8'h3C, 3, 1'b0);
        play();
        check("midload_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ram_we", ram_we, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_led", led, 0);
        check("mid_rst_busy", busy, 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        new_image();
        build_random(NB, 1'b0, 8'h00);
        play();
        check("reset_first_addr", wr_addr_log[wr_base], 0);
        finish_image(6);
        core_done(4'h5, 1'b1);

`ifdef SNN_LOADER_TIMEOUT_EN
        // Ten bytes, long idle, then a complete image from byte 0.
        new_image();
        build_random(10, 1'b0, 8'h00);
        play();
        idle(TB_TO + 40);
        new_image();
        build_random(NB, 1'b0, 8'h00);
        play();
        check("timeout_first_addr", wr_addr_log[wr_base], 0);
        finish_image(7);
        core_done(4'h1, 1'b1);
`endif

        check("tx_start_only_when_rdy", tx_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snn_image_loader.md
# snn_image_loader

Receive-side front end of the `snn` top level. It consumes the byte stream delivered by `uart_rx`, unpacks each byte LSB-first into the 784-entry 1-bit input RAM, and pulses `start` to the SNN core once a full image (98 bytes) is stored. When the core reports a classified digit, the block latches it onto `led` and returns it to the PC as one byte through `uart_tx`.

## Interface
- `NUM_BYTES`, default 98: bytes per image; RAM depth is `8*NUM_BYTES`.
- `ADDR_W`, default 10: input RAM address width.
- `TIMEOUT_CYCLES`, default 1048576: inter-byte timeout. Used only with `SNN_LOADER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock, the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_rdy`  in  1  one-cycle pulse from `uart_rx`: `rx_data` is valid.
- `rx_data`  in  8  received byte.
- `ram_we`  out  1  input RAM write enable.
- `ram_addr`  out  ADDR_W  input RAM bit address.
- `ram_wdata`  out  1  input RAM write bit.
- `start`  out  1  one-cycle pulse: image loaded, core may run.
- `done`  in  1  one-cycle pulse from core: `digit` is valid.
- `digit`  in  4  classified digit, 0–9.
- `tx_start`  out  1  one-cycle pulse to `uart_tx`.
- `tx_data`  out  8  byte to transmit.
- `tx_rdy`  in  1  `uart_tx` idle and able to accept a byte.
- `led`  out  8  last classified digit, zero-extended.
- `busy`  out  1  high in every state except LOAD.
- `overrun`  out  1  sticky error flag for a dropped byte.

## Operation
- States:
  - LOAD: waiting for a byte.
  - WRITE: emitting 8 bits.
  - START.
  - WAIT_CORE.
  - SEND.
- `byte_cnt` (0..NUM_BYTES-1) and `bit_cnt` (0..7) are counters. `byte_reg` is an 8-bit shift register. `hold_reg` with `hold_vld` forms a one-byte skid buffer.
- LOAD:
  - On `rx_rdy`, capture `rx_data` into `byte_reg` and go to WRITE.
  - If `hold_vld`, take `hold_reg` instead and clear `hold_vld`.
- WRITE:
  - Each cycle: `ram_we`=1, `ram_addr`=`8*byte_cnt+bit_cnt`, `ram_wdata`=`byte_reg[bit_cnt]`.
  - After `bit_cnt`=7:
    - If `byte_cnt`=NUM_BYTES-1: clear `byte_cnt`, go to START.
    - Otherwise: increment `byte_cnt` and return to LOAD.
- `rx_rdy` during WRITE:
  - Store the byte in `hold_reg`.
  - If `hold_vld` is already set, drop the byte and set `overrun`.
- START: `start`=1 for one cycle, then go to WAIT_CORE.
- WAIT_CORE:
  - On `done`, latch `digit`. Set `led` and `tx_data` to `{4'h0,digit}`. Go to SEND.
  - `rx_rdy` in WAIT_CORE or SEND drops the byte and sets `overrun`.
- SEND: wait for `tx_rdy`=1, then pulse `tx_start` for one cycle and go to LOAD.
- `overrun` clears only on reset.
- `led` holds its value until the next `done`.
- Reset mid-operation: all counters, the buffer and the state machine return to reset values immediately. A partially loaded image is discarded; RAM contents are not cleared.

## Timing
- Reset values:
  - State: LOAD.
  - `ram_we`, `ram_addr`, `ram_wdata`, `start`, `tx_start`, `busy`, `overrun`: 0.
  - `tx_data`, `led`: 8'h00.
- All outputs are registered.
- Byte latency:
  - `rx_rdy` at cycle N gives writes at cycles N+1..N+8 (bit 0 first).
  - The state is LOAD again at N+9.
- The last byte's bit 7 is written at cycle M, and `start` is high at M+1.
- `done` at cycle D:
  - `led`/`tx_data` are updated at D+1.
  - If `tx_rdy` is already high, `tx_start` is high at D+2.
- `tx_start` is never asserted while `tx_rdy`=0.
- Simultaneous `rx_rdy` and `hold_vld` in LOAD: take `hold_reg`, and place the new byte into `hold_reg`. No loss.

## Configuration
- Macro: `SNN_LOADER_TIMEOUT_EN`.
- Defined:
  - A counter runs in LOAD while `byte_cnt`>0 and no `rx_rdy` arrives.
  - At TIMEOUT_CYCLES it clears `byte_cnt` and `hold_vld`, so the next byte is treated as byte 0 (resync after a PC abort).
  - The counter resets on every `rx_rdy`.
- Undefined: no counter is present, and LOAD waits indefinitely.

## Test plan
- Image load:
  - Stimulus: send 98 bytes 8'hA5 via the `uart_tx` model.
  - Required response: RAM bit pattern 1,0,1,0,0,1,0,1 repeating over addresses 0..783. Exactly one `start` pulse, one cycle after the write to address 783.
- Result return:
  - Stimulus: core `done` with `digit`=4'h7.
  - Required response: `led`=8'h07. The `uart_rx` model receives 8'h07.
- Back-to-back images:
  - Stimulus: images for digits 0, 2 and 9 in sequence.
  - Required response: `led` sequence 8'h00, 8'h02, 8'h09. Three `start` pulses. `overrun`=0.
- Overrun:
  - Stimulus: inject 3 `rx_rdy` pulses within 8 cycles.
  - Required response: first and second bytes written. Third byte dropped. `overrun`=1.
- Reset mid-load:
  - Stimulus: assert `rst_n`=0 after byte 40.
  - Required response: after release, a full 98-byte image produces `start`, with byte 0 written at address 0.
- Timeout, with `SNN_LOADER_TIMEOUT_EN`:
  - Stimulus: 10 bytes, idle for TIMEOUT_CYCLES, then 98 bytes.
  - Required response: `start` after the 98th new byte, not the 88th.
